dart_match_ctrl: RTL and testbench
==================================

# dart_match_ctrl

Parametrised match controller for the dart machine. It sequences N players through turns of up to D darts, counting each player down from a configurable start score. Bust rollback restores the turn-start score. Darts arrive as sector/ring codes from the board-sensor decoder instead of raw x/y positions. It sits between that decoder and the score display/result logic, and exposes per-player scores, a turn-done handshake and a game-set flag.

## Interface
- NUM_PLAYERS, 2: number of players, 2..4; PL_W = $clog2(NUM_PLAYERS)
- START_SCORE, 501: initial score per player
- DARTS_PER_TURN, 3: darts per turn, 1..7
- PT_W, 9: score width; must satisfy 2**PT_W > START_SCORE
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset
- start_i  input  1  begin a new game (honoured only in IDLE or DONE)
- dart_valid_i  input  1  dart code valid
- dart_ready_o  output  1  controller can accept a dart
- dart_sector_i  input  5  sector: 0 = miss, 1..20, 25 = bull
- dart_ring_i  input  2  0 = miss, 1 = single, 2 = double, 3 = triple
- cur_player_o  output  PL_W  player whose turn it is
- dart_idx_o  output  3  darts already thrown this turn
- last_pt_o  output  8  value of the most recently scored dart
- turn_done_o  output  1  one-cycle pulse when a turn ends
- bust_o  output  1  one-cycle pulse coincident with turn_done_o when the turn busted
- scores_o  output  NUM_PLAYERS*PT_W  player p's score at bits [p*PT_W +: PT_W]
- game_set_o  output  1  high while in DONE
- winner_o  output  PL_W  winning player, valid while game_set_o = 1

## Operation
- States:
  - IDLE: after reset; start_i -> INIT.
  - INIT: all scores <= START_SCORE; cur_player = 0; dart_idx = 0; turn snapshot <= START_SCORE -> WAIT.
  - WAIT: dart_ready_o = 1; valid && ready -> SCORE.
  - SCORE: dart value registered into last_pt_o -> CHECK.
  - CHECK: compares value with rem = score[cur_player] and updates the score -> WAIT, TURN_END or DONE.
  - TURN_END: pulses turn_done_o/bust_o; cur_player advances, wrapping NUM_PLAYERS-1 -> 0; dart_idx = 0; snapshot <= new player's score -> WAIT.
  - DONE: game_set_o = 1; start_i -> INIT.
- Dart value:
  - Ring 0 or sector 0 -> 0.
  - Sector 1..20 -> sector × ring.
  - Bull: single 25, double 50, triple invalid -> 0.
  - Sectors 21..24 and 26..31 -> 0.
  - Invalid codes still consume a dart.
- CHECK outcomes:
  - value > rem: bust. Score <= snapshot, go to TURN_END with bust flag.
  - value == rem: score <= 0; winner_o <= cur_player -> DONE. turn_done_o is not pulsed.
  - Otherwise: score -= value and dart_idx increments. If dart_idx reaches DARTS_PER_TURN -> TURN_END, else -> WAIT.
- Arithmetic: the dart value is a 6-bit result zero-extended to PT_W. Comparison is unsigned, so scores never go negative.
- start_i outside IDLE/DONE is ignored. dart_valid_i outside WAIT is ignored, and nothing is queued.
- Reset mid-game: every register returns to its reset value next edge; an in-flight dart is discarded.

## Timing
- Reset values: dart_ready_o 0, cur_player_o 0, dart_idx_o 0, last_pt_o 0, turn_done_o 0, bust_o 0, scores_o all 0, game_set_o 0, winner_o 0.
- start_i sampled in cycle T: INIT at T+1, WAIT (ready = 1, scores = START_SCORE) at T+2.
- Dart accepted at cycle A: last_pt_o valid from A+2; score updated from A+3; next decision state at A+3.
- Accept-to-ready latency:
  - 3 cycles within a turn.
  - 4 cycles across a turn end (TURN_END lasts one cycle).
- cur_player_o and dart_idx_o change at the end of TURN_END. During the turn_done_o pulse they still show the finishing player and its final count.
- dart_ready_o is low in IDLE, INIT, SCORE, CHECK, TURN_END and DONE.

## Configuration
- DOUBLE_OUT_EN defined:
  - A checkout (value == rem) counts only if ring = 2, including double bull 50. Otherwise it is a bust.
  - Any dart leaving rem - value == 1 is also a bust.
- DOUBLE_OUT_EN undefined: any exact hit of 0 wins; remainder 1 is legal.

## Test plan
- Reset then start_i, defaults: scores_o = {501,501}, cur_player 0, ready at T+2. Three triple-20s -> P0 = 321, turn_done_o pulse with bust_o = 0, cur_player -> 1.
- Bust rollback: P0 at 40 at turn start. Throw single 20 (-> 20), then triple 20 -> bust_o + turn_done_o; P0 restored to 40; next player 1.
- Checkout: P1 at 50, double bull -> score 0, game_set_o = 1, winner_o = 1. Further darts and start_i = 0 produce no change.
- Invalid codes: sector 25 ring 3, then sector 22 ring 1 -> last_pt_o = 0 for both, dart_idx = 2, score unchanged.
- NUM_PLAYERS = 3, DARTS_PER_TURN = 1: three misses -> cur_player sequence 0, 1, 2, 0. Reset asserted mid-SCORE -> all outputs return to reset values.
- With DOUBLE_OUT_EN, P0 at 20:
  - Single 20 -> bust, restored to 20.
  - Single 19 -> bust (remainder 1).
  - Double 10 -> win.

Source files
------------

// File: rtl/dart_match_ctrl.sv
// rtl/dart_match_ctrl.sv - dart match sequencer: turns, dart scoring, bust rollback, checkout
//
// Optional feature macro: DOUBLE_OUT_EN (checkout only on a double; remainder 1 busts)
//
// Ports:
//   clk, reset        clock, synchronous active-low reset
//   start_i           begin a new game (IDLE/DONE only)
//   dart_valid_i      dart code valid; accepted when dart_ready_o is high
//   dart_ready_o      controller is waiting for a dart
//   dart_sector_i     0 = miss, 1..20, 25 = bull
//   dart_ring_i       0 = miss, 1 = single, 2 = double, 3 = triple
//   cur_player_o      player whose turn it is
//   dart_idx_o        darts already scored this turn
//   last_pt_o         value of the most recently scored dart
//   turn_done_o       one-cycle pulse when a turn ends
//   bust_o            coincident with turn_done_o when the turn busted
//   scores_o          player p's score at [p*PT_W +: PT_W]
//   game_set_o        high while the game is over
//   winner_o          winning player, valid while game_set_o is high
module dart_match_ctrl #(
  parameter int NUM_PLAYERS    = 2,
  parameter int START_SCORE    = 501,
  parameter int DARTS_PER_TURN = 3,
  parameter int PT_W           = 9,
  localparam int PL_W          = $clog2(NUM_PLAYERS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start_i,
  input  logic                        dart_valid_i,
  output logic                        dart_ready_o,
  input  logic [4:0]                  dart_sector_i,
  input  logic [1:0]                  dart_ring_i,
  output logic [PL_W-1:0]             cur_player_o,
  output logic [2:0]                  dart_idx_o,
  output logic [7:0]                  last_pt_o,
  output logic                        turn_done_o,
  output logic                        bust_o,
  output logic [NUM_PLAYERS*PT_W-1:0] scores_o,
  output logic                        game_set_o,
  output logic [PL_W-1:0]             winner_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_WAIT,
    S_SCORE,
    S_CHECK,
    S_TURN_END,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [4:0]                  sector_q;
  logic [1:0]                  ring_q;
  logic [7:0]                  last_pt_q;
  logic [NUM_PLAYERS*PT_W-1:0] scores_q;
  logic [PT_W-1:0]             snap_q;
  logic [PL_W-1:0]             cur_player_q;
  logic [2:0]                  dart_idx_q;
  logic [PL_W-1:0]             winner_q;
  logic                        bust_q;

  logic [5:0]                  dart_val;
  logic [PT_W-1:0]             rem;
  logic [PT_W-1:0]             val_ext;
  logic [2:0]                  idx_next;
  logic                        turn_full;
  logic                        chk_bust;
  logic                        chk_win;
  logic [PL_W-1:0]             next_player;

  // Dart value from the codes captured at acceptance; unknown codes score 0
  // but still use up a dart.
  always_comb begin
    dart_val = '0;
    if (ring_q != 2'd0 && sector_q != 5'd0) begin
      if (sector_q <= 5'd20) begin
        dart_val = 6'(sector_q) * 6'(ring_q);
      end else if (sector_q == 5'd25 && ring_q != 2'd3) begin
        dart_val = (ring_q == 2'd2) ? 6'd50 : 6'd25;
      end
    end
  end

  assign rem       = scores_q[cur_player_q*PT_W +: PT_W];
  assign val_ext   = PT_W'(last_pt_q[5:0]);
  assign idx_next  = dart_idx_q + 3'd1;
  assign turn_full = (idx_next == 3'(DARTS_PER_TURN));

  assign next_player = (cur_player_q == PL_W'(NUM_PLAYERS - 1)) ? '0
                                                                : cur_player_q + PL_W'(1);

  // Outcome of the dart held in last_pt_q against the current remainder.
  // The compare is unsigned and a bust is taken before any subtraction,
  // so a score can never wrap below zero.
  always_comb begin
    chk_bust = 1'b0;
    chk_win  = 1'b0;
    if (val_ext > rem) begin
      chk_bust = 1'b1;
    end else if (val_ext == rem) begin
`ifdef DOUBLE_OUT_EN
      if (ring_q == 2'd2) chk_win = 1'b1;
      else                chk_bust = 1'b1;
`else
      chk_win = 1'b1;
`endif
    end
`ifdef DOUBLE_OUT_EN
    else if (rem - val_ext == PT_W'(1)) begin
      chk_bust = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    dart_ready_o = 1'b0;
    turn_done_o  = 1'b0;
    bust_o       = 1'b0;
    game_set_o   = 1'b0;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_INIT;
      S_INIT:  state_d = S_WAIT;
      S_WAIT: begin
        dart_ready_o = 1'b1;
        if (dart_valid_i) state_d = S_SCORE;
      end
      S_SCORE: state_d = S_CHECK;
      S_CHECK: begin
        if (chk_bust)       state_d = S_TURN_END;
        else if (chk_win)   state_d = S_DONE;
        else if (turn_full) state_d = S_TURN_END;
        else                state_d = S_WAIT;
      end
      S_TURN_END: begin
        turn_done_o = 1'b1;
        bust_o      = bust_q;
        state_d     = S_WAIT;
      end
      S_DONE: begin
        game_set_o = 1'b1;
        if (start_i) state_d = S_INIT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sector_q     <= '0;
      ring_q       <= '0;
      last_pt_q    <= '0;
      scores_q     <= '0;
      snap_q       <= '0;
      cur_player_q <= '0;
      dart_idx_q   <= '0;
      winner_q     <= '0;
      bust_q       <= 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          scores_q     <= {NUM_PLAYERS{PT_W'(START_SCORE)}};
          snap_q       <= PT_W'(START_SCORE);
          cur_player_q <= '0;
          dart_idx_q   <= '0;
          bust_q       <= 1'b0;
        end
        S_WAIT: begin
          if (dart_valid_i) begin
            sector_q <= dart_sector_i;
            ring_q   <= dart_ring_i;
          end
        end
        S_SCORE: last_pt_q <= {2'b00, dart_val};
        S_CHECK: begin
          bust_q <= chk_bust;
          if (chk_bust) begin
            // Roll the whole turn back, not just this dart.
            scores_q[cur_player_q*PT_W +: PT_W] <= snap_q;
          end else if (chk_win) begin
            scores_q[cur_player_q*PT_W +: PT_W] <= '0;
            winner_q                            <= cur_player_q;
          end else begin
            scores_q[cur_player_q*PT_W +: PT_W] <= rem - val_ext;
            dart_idx_q                          <= idx_next;
          end
        end
        S_TURN_END: begin
          cur_player_q <= next_player;
          dart_idx_q   <= '0;
          snap_q       <= scores_q[next_player*PT_W +: PT_W];
        end
        default: ;
      endcase
    end
  end

  assign cur_player_o = cur_player_q;
  assign dart_idx_o   = dart_idx_q;
  assign last_pt_o    = last_pt_q;
  assign scores_o     = scores_q;
  assign winner_o     = winner_q;

endmodule

// File: tb/tb_dart_match_ctrl.sv
// tb/tb_dart_match_ctrl.sv - scoreboard bench for dart_match_ctrl (2p/3d default and 3p/1d instances)
module tb_dart_match_ctrl;

  localparam int PT_W = 9;

  logic clk;
  logic reset;

  // Instance A: defaults (2 players, 3 darts, 501)
  logic        start_a, valid_a, ready_a;
  logic [4:0]  sector_a;
  logic [1:0]  ring_a;
  logic [0:0]  cur_a, winner_a;
  logic [2:0]  idx_a;
  logic [7:0]  last_a;
  logic        tdone_a, bust_a, gset_a;
  logic [17:0] scores_a;

  // Instance B: 3 players, 1 dart per turn
  logic        start_b, valid_b, ready_b;
  logic [4:0]  sector_b;
  logic [1:0]  ring_b;
  logic [1:0]  cur_b, winner_b;
  logic [2:0]  idx_b;
  logic [7:0]  last_b;
  logic        tdone_b, bust_b, gset_b;
  logic [26:0] scores_b;

  dart_match_ctrl u_dut (
    .clk(clk), .reset(reset), .start_i(start_a),
    .dart_valid_i(valid_a), .dart_ready_o(ready_a),
    .dart_sector_i(sector_a), .dart_ring_i(ring_a),
    .cur_player_o(cur_a), .dart_idx_o(idx_a), .last_pt_o(last_a),
    .turn_done_o(tdone_a), .bust_o(bust_a), .scores_o(scores_a),
    .game_set_o(gset_a), .winner_o(winner_a)
  );

  dart_match_ctrl #(.NUM_PLAYERS(3), .DARTS_PER_TURN(1)) u_dut3 (
    .clk(clk), .reset(reset), .start_i(start_b),
    .dart_valid_i(valid_b), .dart_ready_o(ready_b),
    .dart_sector_i(sector_b), .dart_ring_i(ring_b),
    .cur_player_o(cur_b), .dart_idx_o(idx_b), .last_pt_o(last_b),
    .turn_done_o(tdone_b), .bust_o(bust_b), .scores_o(scores_b),
    .game_set_o(gset_b), .winner_o(winner_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int pt;
    int player;
    int score;
    int idx;
    int nplayer;
    bit tend;
    bit bust;
    bit win;
  } exp_t;

  exp_t sb[$];

  int m_score[2];
  int m_player;
  int m_idx;
  int m_snap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_start();
    m_score[0] = 501;
    m_score[1] = 501;
    m_player   = 0;
    m_idx      = 0;
    m_snap     = 501;
  endtask

  // Throw one dart into instance A; val is the dart's expected point value.
  task automatic throw_a(input logic [4:0] sec, input logic [1:0] rg, input int val);
    exp_t e;
    int   rem;
    int   n;
    bit   do_bust;
    bit   do_win;
    n = 0;
    while (ready_a !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", ready_a, 1);

    rem     = m_score[m_player];
    do_bust = 0;
    do_win  = 0;
    if (val > rem) do_bust = 1;
    else if (val == rem) begin
`ifdef DOUBLE_OUT_EN
      if (rg == 2'd2) do_win = 1;
      else            do_bust = 1;
`else
      do_win = 1;
`endif
    end
`ifdef DOUBLE_OUT_EN
    else if (rem - val == 1) do_bust = 1;
`endif
    e.pt = val; e.player = m_player; e.tend = 0; e.bust = do_bust; e.win = do_win;
    if (do_bust) begin
      m_score[m_player] = m_snap;
      e.tend = 1;
    end else if (do_win) begin
      m_score[m_player] = 0;
    end else begin
      m_score[m_player] -= val;
      m_idx++;
      if (m_idx == 3) e.tend = 1;
    end
    e.score = m_score[m_player];
    e.idx   = m_idx;
    e.nplayer = m_player;
    if (e.tend) begin
      m_player  = (m_player + 1) % 2;
      m_idx     = 0;
      m_snap    = m_score[m_player];
      e.nplayer = m_player;
    end
    sb.push_back(e);

    valid_a = 1'b1; sector_a = sec; ring_a = rg;
    @(negedge clk);
    valid_a = 1'b0; sector_a = '0; ring_a = '0;
    chk("ready_in_score", ready_a, 0);
    @(negedge clk);
    e = sb.pop_front();
    chk("last_pt", last_a, e.pt);
    @(negedge clk);
    chk("score", scores_a[e.player*PT_W +: PT_W], e.score);
    if (e.win) begin
      chk("game_set", gset_a, 1);
      chk("winner", winner_a, e.player);
      chk("no_tdone_on_win", tdone_a, 0);
    end else if (e.tend) begin
      chk("turn_done", tdone_a, 1);
      chk("bust", bust_a, e.bust);
      chk("tend_player", cur_a, e.player);
      chk("tend_idx", idx_a, e.idx);
      @(negedge clk);
      chk("next_player", cur_a, e.nplayer);
      chk("next_idx", idx_a, 0);
      chk("next_ready", ready_a, 1);
    end else begin
      chk("ready_again", ready_a, 1);
      chk("dart_idx", idx_a, e.idx);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    start_a = 0; valid_a = 0; sector_a = '0; ring_a = '0;
    start_b = 0; valid_b = 0; sector_b = '0; ring_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    chk("rst_ready", ready_a, 0);
    chk("rst_cur", cur_a, 0);
    chk("rst_idx", idx_a, 0);
    chk("rst_last", last_a, 0);
    chk("rst_tdone", tdone_a, 0);
    chk("rst_bust", bust_a, 0);
    chk("rst_scores", scores_a, 0);
    chk("rst_gset", gset_a, 0);
    chk("rst_winner", winner_a, 0);

    // Start: INIT at T+1, WAIT at T+2.
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("init_ready", ready_a, 0);
    @(negedge clk);
    chk("start_ready", ready_a, 1);
    chk("start_scores", scores_a, {9'd501, 9'd501});
    model_start();

    throw_a(5'd20, 2'd3, 60);
    throw_a(5'd20, 2'd3, 60);
    throw_a(5'd20, 2'd3, 60);
    chk("p0_321", scores_a[0 +: PT_W], 321);

    // start_i mid-game is ignored.
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    chk("start_ignored_ready", ready_a, 1);
    chk("start_ignored_p0", scores_a[0 +: PT_W], 321);

    throw_a(5'd20, 2'd3, 60);
    throw_a(5'd20, 2'd3, 60);
    throw_a(5'd20, 2'd3, 60);
    throw_a(5'd20, 2'd3, 60);
    throw_a(5'd20, 2'd3, 60);
    throw_a(5'd20, 2'd3, 60);
    throw_a(5'd20, 2'd3, 60);
    throw_a(5'd20, 2'd3, 60);
    throw_a(5'd20, 2'd3, 60);
    // P0 141 -> 40
    throw_a(5'd17, 2'd3, 51);
    throw_a(5'd25, 2'd2, 50);
    throw_a(5'd0,  2'd1, 0);
    // P1 141: invalid codes consume darts without scoring
    throw_a(5'd25, 2'd3, 0);
    throw_a(5'd22, 2'd1, 0);
    chk("invalid_idx", idx_a, 2);
    chk("invalid_score", scores_a[PT_W +: PT_W], 141);
    throw_a(5'd17, 2'd3, 51);
    // P0 at 40: single 20 then triple 20 busts back to 40
    throw_a(5'd20, 2'd1, 20);
    throw_a(5'd20, 2'd3, 60);
    chk("bust_restore", scores_a[0 +: PT_W], 40);
    // P1 90 -> 50
    throw_a(5'd20, 2'd2, 40);
    throw_a(5'd0,  2'd0, 0);
    throw_a(5'd5,  2'd0, 0);
    // P0 misses
    throw_a(5'd0,  2'd0, 0);
    throw_a(5'd0,  2'd1, 0);
    throw_a(5'd7,  2'd0, 0);
    // P1 checks out on double bull
    throw_a(5'd25, 2'd2, 50);

    // After the game: darts and a low start_i change nothing.
    valid_a = 1'b1; sector_a = 5'd20; ring_a = 2'd3;
    repeat (5) begin
      @(negedge clk);
      chk("done_ready", ready_a, 0);
    end
    valid_a = 1'b0;
    chk("done_scores", scores_a, {9'd0, 9'd40});
    chk("done_gset", gset_a, 1);
    chk("done_winner", winner_a, 1);

    // Restart from DONE.
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("restart_gset", gset_a, 0);
    @(negedge clk);
    chk("restart_ready", ready_a, 1);
    chk("restart_scores", scores_a, {9'd501, 9'd501});
    chk("restart_cur", cur_a, 0);

    // Instance B: one-dart turns rotate 0,1,2,0.
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      int n;
      n = 0;
      while (ready_b !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("b_ready", ready_b, 1);
      chk("b_cur", cur_b, k);
      valid_b = 1'b1;
      @(negedge clk);
      valid_b = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("b_tdone", tdone_b, 1);
      chk("b_bust", bust_b, 0);
      @(negedge clk);
      chk("b_next", cur_b, (k + 1) % 3);
    end
    chk("b_scores", scores_b, {9'd501, 9'd501, 9'd501});

    // Reset while B is in SCORE discards the dart.
    sector_b = 5'd20; ring_b = 2'd3; valid_b = 1'b1;
    @(negedge clk);
    valid_b = 1'b0;
    chk("b_in_score", ready_b, 0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("b_rst_ready", ready_b, 0);
    chk("b_rst_cur", cur_b, 0);
    chk("b_rst_idx", idx_b, 0);
    chk("b_rst_last", last_b, 0);
    chk("b_rst_tdone", tdone_b, 0);
    chk("b_rst_bust", bust_b, 0);
    chk("b_rst_scores", scores_b, 0);
    chk("b_rst_gset", gset_b, 0);
    chk("b_rst_winner", winner_b, 0);
    chk("a_rst_scores", scores_a, 0);
    chk("a_rst_ready", ready_a, 0);
    @(negedge clk);
    chk("b_stays_idle", ready_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
